// File: rtl/line_fill_buffer_p_if.sv
// ============================================================================
// Module      : line_fill_buffer_p_if
// Description : Bundle of the line fill stage's request, memory-burst and
//               data-array write signals.
//               slave  : the fill stage (line_fill_buffer_p)
//               master : the surrounding cache controller / memory / array
// Ports       : fill request side : fill_req, fill_index, fill_addr,
//                                   st_valid, st_mask, st_data
//               memory burst side : pmem_read, pmem_address, pmem_resp,
//                                   pmem_rdata
//               array write side  : arr_write_en, arr_windex, arr_datain
//               status            : fill_busy, fill_done
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface line_fill_buffer_p_if #(
   parameter int S_OFFSET = 5,
   parameter int S_INDEX  = 3,
   parameter int S_BEAT   = 64
);
   localparam int S_MASK = 2 ** S_OFFSET;
   localparam int S_LINE = 8 * S_MASK;

   // fill request
   logic                fill_req;
   logic [S_INDEX-1:0]  fill_index;
   logic [31:0]         fill_addr;
   logic                st_valid;
   logic [S_MASK-1:0]   st_mask;
   logic [S_LINE-1:0]   st_data;

   // memory burst
   logic                pmem_read;
   logic [31:0]         pmem_address;
   logic                pmem_resp;
   logic [S_BEAT-1:0]   pmem_rdata;

   // data array write port
   logic [S_MASK-1:0]   arr_write_en;
   logic [S_INDEX-1:0]  arr_windex;
   logic [S_LINE-1:0]   arr_datain;

   // status
   logic                fill_busy;
   logic                fill_done;

   modport slave (
      input  fill_req, fill_index, fill_addr, st_valid, st_mask, st_data,
      input  pmem_resp, pmem_rdata,
      output pmem_read, pmem_address,
      output arr_write_en, arr_windex, arr_datain,
      output fill_busy, fill_done
   );

   modport master (
      output fill_req, fill_index, fill_addr, st_valid, st_mask, st_data,
      output pmem_resp, pmem_rdata,
      input  pmem_read, pmem_address,
      input  arr_write_en, arr_windex, arr_datain,
      input  fill_busy, fill_done
   );

endinterface

`default_nettype wire

// File: rtl/line_fill_buffer_p.sv
// ============================================================================
// Module      : line_fill_buffer_p
// Description : Miss-side line fill stage in front of the pipelined cache data
//               array. On fill_req it issues a burst read for the line holding
//               fill_addr, assembles the line from S_BEAT-wide beats (beat 0 is
//               the lowest-addressed part), then performs one full-line write
//               into the data array and pulses fill_done.
//               FSM: IDLE -> BURST -> WRITE -> IDLE.
// Ports       : clk      - clock, all state on rising edge
//               rst      - asynchronous active-high reset
//               io_fill  - line_fill_buffer_p_if.slave (request, memory
//                          burst, array write port, status)
// Config      : STORE_MERGE_EN - when defined, a pending store (st_valid,
//               st_mask, st_data) latched with fill_req is merged byte-wise
//               over the filled line before the array write. When undefined
//               the st_* signals are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_fill_buffer_p #(
   parameter int S_OFFSET = 5,
   parameter int S_INDEX  = 3,
   parameter int S_BEAT   = 64
) (
   input  wire                     clk,
   input  wire                     rst,
   line_fill_buffer_p_if.slave     io_fill
);

   localparam int S_MASK = 2 ** S_OFFSET;
   localparam int S_LINE = 8 * S_MASK;
   localparam int BEATS  = S_LINE / S_BEAT;
   localparam int CW     = (BEATS > 1) ? $clog2(BEATS) : 1;

   localparam logic [CW-1:0] C_LAST_BEAT = CW'(BEATS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BURST = 2'd1,
      ST_WRITE = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_next;

   logic [CW-1:0]         r_beat_cnt;
   logic [S_LINE-1:0]     r_buf;
   logic [S_INDEX-1:0]    r_index;
   logic [31:0]           r_addr;

   // Array write-port data/index are registered so they stay stable outside
   // WRITE; they are loaded on the last beat so the WRITE cycle already sees
   // the complete (and possibly merged) line.
   logic [S_LINE-1:0]     r_arr_datain;
   logic [S_INDEX-1:0]    r_arr_windex;

   logic                  w_accept;
   logic                  w_beat;
   logic                  w_last_beat;
   logic [S_LINE-1:0]     w_buf_next;
   logic [S_LINE-1:0]     w_line_out;

   // Only the line-aligned part of the miss address is used.
   logic                  w_unused_addr;
   assign w_unused_addr = ^io_fill.fill_addr[S_OFFSET-1:0];

   // -------------------------------------------------------------------------
   // Handshake decode
   // -------------------------------------------------------------------------
   assign w_accept    = (r_state == ST_IDLE)  && io_fill.fill_req;
   assign w_beat      = (r_state == ST_BURST) && io_fill.pmem_resp;
   assign w_last_beat = w_beat && (r_beat_cnt == C_LAST_BEAT);

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // -------------------------------------------------------------------------
   // FSM: next state and decoded outputs
   // -------------------------------------------------------------------------
   always_comb begin
      w_state_next         = r_state;
      io_fill.pmem_read    = 1'b0;
      io_fill.fill_busy    = 1'b0;
      io_fill.fill_done    = 1'b0;
      io_fill.arr_write_en = '0;

      case (r_state)
         ST_IDLE: begin
            if (io_fill.fill_req) begin
               w_state_next = ST_BURST;
            end
         end
         ST_BURST: begin
            io_fill.pmem_read = 1'b1;
            io_fill.fill_busy = 1'b1;
            if (w_last_beat) begin
               w_state_next = ST_WRITE;
            end
         end
         ST_WRITE: begin
            io_fill.fill_busy    = 1'b1;
            io_fill.fill_done    = 1'b1;
            io_fill.arr_write_en = '1;
            w_state_next         = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Beat insertion: the incoming beat lands in the slot picked by r_beat_cnt.
   // -------------------------------------------------------------------------
   always_comb begin
      w_buf_next = r_buf;
      for (int b = 0; b < BEATS; b++) begin
         if (r_beat_cnt == CW'(b)) begin
            w_buf_next[b*S_BEAT +: S_BEAT] = io_fill.pmem_rdata;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Optional pending-store merge
   // -------------------------------------------------------------------------
`ifdef STORE_MERGE_EN
   logic                  r_st_valid;
   logic [S_MASK-1:0]     r_st_mask;
   logic [S_LINE-1:0]     r_st_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_st_valid <= 1'b0;
         r_st_mask  <= '0;
         r_st_data  <= '0;
      end else if (w_accept) begin
         r_st_valid <= io_fill.st_valid;
         r_st_mask  <= io_fill.st_mask;
         r_st_data  <= io_fill.st_data;
      end
   end

   // Store bytes win over memory bytes where the store mask is set.
   always_comb begin
      w_line_out = w_buf_next;
      for (int i = 0; i < S_MASK; i++) begin
         if (r_st_valid && r_st_mask[i]) begin
            w_line_out[8*i +: 8] = r_st_data[8*i +: 8];
         end
      end
   end
`else
   logic                  w_unused_st;
   assign w_unused_st = ^{io_fill.st_valid, io_fill.st_mask, io_fill.st_data};
   assign w_line_out  = w_buf_next;
`endif

   // -------------------------------------------------------------------------
   // Datapath registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_beat_cnt   <= '0;
         r_buf        <= '0;
         r_index      <= '0;
         r_addr       <= '0;
         r_arr_datain <= '0;
         r_arr_windex <= '0;
      end else begin
         if (w_accept) begin
            r_index    <= io_fill.fill_index;
            r_addr     <= {io_fill.fill_addr[31:S_OFFSET], {S_OFFSET{1'b0}}};
            r_beat_cnt <= '0;
         end
         if (w_beat) begin
            r_buf <= w_buf_next;
            // The last beat leaves BURST, so the counter is parked at zero
            // instead of wrapping.
            if (w_last_beat) begin
               r_beat_cnt <= '0;
            end else begin
               r_beat_cnt <= r_beat_cnt + 1'b1;
            end
         end
         if (w_last_beat) begin
            r_arr_datain <= w_line_out;
            r_arr_windex <= r_index;
         end
      end
   end

   assign io_fill.pmem_address = r_addr;
   assign io_fill.arr_datain   = r_arr_datain;
   assign io_fill.arr_windex   = r_arr_windex;

endmodule

`default_nettype wire

// File: tb/tb_line_fill_buffer_p.sv
// ============================================================================
// Module      : tb_line_fill_buffer_p
// Description : Directed self-checking bench for line_fill_buffer_p with the
//               default geometry (32-byte line, 8 sets, 64-bit beats, 4 beats).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_line_fill_buffer_p;

   logic clk;
   logic rst;

   int checks;
   int errors;
   int n_writes;

   localparam logic [255:0] C_LINE0 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                       64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
   localparam logic [255:0] C_LINE1 = {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
                                       64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555};

   logic [63:0] beat_v [8];

   line_fill_buffer_p_if #(.S_OFFSET(5), .S_INDEX(3), .S_BEAT(64)) u_if ();

   line_fill_buffer_p #(.S_OFFSET(5), .S_INDEX(3), .S_BEAT(64)) u_dut (
      .clk     (clk),
      .rst     (rst),
      .io_fill (u_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Number of array write cycles seen at rising edges.
   always @(posedge clk or posedge rst) begin
      if (u_if.arr_write_en != '0) n_writes <= n_writes + 1;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic start_fill(input logic [2:0] idx, input logic [31:0] addr,
                             input logic [31:0] exp_addr);
      u_if.fill_req   = 1'b1;
      u_if.fill_index = idx;
      u_if.fill_addr  = addr;
      tick();
      u_if.fill_req   = 1'b0;
      chk("busy_after_req", u_if.fill_busy, 1'b1);
      chk("pmem_read_after_req", u_if.pmem_read, 1'b1);
      chk("pmem_address", u_if.pmem_address, exp_addr);
   endtask

   // Sends four beats from beat set 'set', with 'stall' idle cycles before each.
   task automatic send_beats(input int set, input int stall);
      for (int b = 0; b < 4; b++) begin
         repeat (stall) tick();
         u_if.pmem_resp  = 1'b1;
         u_if.pmem_rdata = beat_v[set*4 + b];
         tick();
         u_if.pmem_resp  = 1'b0;
      end
   endtask

   initial begin
      int n0;
      logic [255:0] exp_line;

      checks   = 0;
      errors   = 0;
      n_writes = 0;
      beat_v[0] = 64'h1111_1111_1111_1111;
      beat_v[1] = 64'h2222_2222_2222_2222;
      beat_v[2] = 64'h3333_3333_3333_3333;
      beat_v[3] = 64'h4444_4444_4444_4444;
      beat_v[4] = 64'h5555_5555_5555_5555;
      beat_v[5] = 64'h6666_6666_6666_6666;
      beat_v[6] = 64'h7777_7777_7777_7777;
      beat_v[7] = 64'h8888_8888_8888_8888;

      rst             = 1'b0;
      u_if.fill_req   = 1'b0;
      u_if.fill_index = '0;
      u_if.fill_addr  = '0;
      u_if.st_valid   = 1'b0;
      u_if.st_mask    = '0;
      u_if.st_data    = '0;
      u_if.pmem_resp  = 1'b0;
      u_if.pmem_rdata = '0;

      // 1: asynchronous reset mid-cycle, before any clock edge
      #3 rst = 1'b1;
      #1;
      chk("rst_pmem_read", u_if.pmem_read, 1'b0);
      chk("rst_pmem_address", u_if.pmem_address, 32'h0);
      chk("rst_arr_write_en", u_if.arr_write_en, 32'h0);
      chk("rst_arr_windex", u_if.arr_windex, 3'd0);
      chk("rst_arr_datain", u_if.arr_datain, 256'h0);
      chk("rst_fill_done", u_if.fill_done, 1'b0);
      chk("rst_fill_busy", u_if.fill_busy, 1'b0);
      tick();
      rst = 1'b0;
      n_writes = 0;
      tick();
      chk("idle_busy", u_if.fill_busy, 1'b0);

      // 2: basic back-to-back fill
      start_fill(3'd3, 32'h1234_5678, 32'h1234_5660);
      send_beats(0, 0);
      chk("t2_write_en", u_if.arr_write_en, 32'hFFFF_FFFF);
      chk("t2_windex", u_if.arr_windex, 3'd3);
      chk("t2_datain", u_if.arr_datain, C_LINE0);
      chk("t2_fill_done", u_if.fill_done, 1'b1);
      tick();
      chk("t2_done_drop", u_if.fill_done, 1'b0);
      chk("t2_write_en_drop", u_if.arr_write_en, 32'h0);
      chk("t2_pmem_read_drop", u_if.pmem_read, 1'b0);
      chk("t2_busy_drop", u_if.fill_busy, 1'b0);
      chk("t2_datain_held", u_if.arr_datain, C_LINE0);
      chk("t2_write_count", n_writes, 1);

      // 3: stalled burst, two idle cycles before every beat
      n0 = n_writes;
      start_fill(3'd3, 32'h1234_5678, 32'h1234_5660);
      send_beats(0, 2);
      chk("t3_fill_done", u_if.fill_done, 1'b1);
      chk("t3_datain", u_if.arr_datain, C_LINE0);
      chk("t3_windex", u_if.arr_windex, 3'd3);
      repeat (3) tick();
      chk("t3_write_once", n_writes, n0 + 1);

      // 4: request during BURST is ignored; request during WRITE is ignored;
      //    request in the IDLE cycle right after is accepted
      start_fill(3'd3, 32'h1234_5678, 32'h1234_5660);
      u_if.fill_req   = 1'b1;
      u_if.fill_index = 3'd5;
      u_if.fill_addr  = 32'hFFFF_FFE0;
      tick();
      u_if.fill_req   = 1'b0;
      chk("t4_addr_held", u_if.pmem_address, 32'h1234_5660);
      send_beats(0, 0);
      chk("t4_windex_orig", u_if.arr_windex, 3'd3);
      chk("t4_fill_done", u_if.fill_done, 1'b1);
      u_if.fill_req   = 1'b1;
      u_if.fill_index = 3'd6;
      u_if.fill_addr  = 32'h0000_0100;
      tick();
      chk("t4_req_in_write_ignored", u_if.fill_busy, 1'b0);
      start_fill(3'd6, 32'h0000_0100, 32'h0000_0100);
      send_beats(1, 0);
      chk("t4_windex_new", u_if.arr_windex, 3'd6);
      chk("t4_datain_new", u_if.arr_datain, C_LINE1);
      tick();

      // 5: reset after two beats aborts the fill
      n0 = n_writes;
      start_fill(3'd2, 32'h0000_003F, 32'h0000_0020);
      for (int b = 0; b < 2; b++) begin
         u_if.pmem_resp  = 1'b1;
         u_if.pmem_rdata = beat_v[4 + b];
         tick();
      end
      u_if.pmem_resp = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("t5_rst_busy", u_if.fill_busy, 1'b0);
      chk("t5_rst_pmem_read", u_if.pmem_read, 1'b0);
      chk("t5_rst_address", u_if.pmem_address, 32'h0);
      tick();
      rst = 1'b0;
      for (int b = 2; b < 4; b++) begin
         u_if.pmem_resp  = 1'b1;
         u_if.pmem_rdata = beat_v[4 + b];
         tick();
      end
      u_if.pmem_resp = 1'b0;
      tick();
      chk("t5_no_write", n_writes, n0);
      chk("t5_busy_idle", u_if.fill_busy, 1'b0);
      chk("t5_datain_cleared", u_if.arr_datain, 256'h0);
      start_fill(3'd1, 32'h0000_0040, 32'h0000_0040);
      send_beats(0, 0);
      chk("t5_new_line", u_if.arr_datain, C_LINE0);
      chk("t5_new_windex", u_if.arr_windex, 3'd1);
      tick();
      chk("t5_one_write", n_writes, n0 + 1);

      // 6: pending store latched with the request, then removed
      u_if.st_valid = 1'b1;
      u_if.st_mask  = 32'h0000_000F;
      u_if.st_data  = {{224{1'b1}}, 32'hDEAD_BEEF};
      start_fill(3'd4, 32'h1234_5678, 32'h1234_5660);
      u_if.st_valid = 1'b0;
      u_if.st_mask  = '0;
      u_if.st_data  = '0;
      send_beats(0, 0);
`ifdef STORE_MERGE_EN
      exp_line = {C_LINE0[255:32], 32'hDEAD_BEEF};
`else
      exp_line = C_LINE0;
`endif
      chk("t6_datain", u_if.arr_datain, exp_line);
      chk("t6_write_en", u_if.arr_write_en, 32'hFFFF_FFFF);
      chk("t6_windex", u_if.arr_windex, 3'd4);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
